// File: rtl/rd_burst_server.sv
// Read-burst responder: grants one requesting channel round-robin, fetches a
// 1 KiB-aligned AXI4 INCR burst from rbase + radr and streams the beats back.
module rd_burst_server #(
  parameter int Np   = 1,
  parameter int BLEN = 128
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [Np-1:0]       rreq,
  output logic [Np-1:0]       rack,
  input  logic [Np-1:0][23:0] radr,
  output logic [Np-1:0][63:0] rdata,
  input  logic [31:0]         rbase,
  output logic [31:0]         m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [63:0]         m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                busy,
  output logic                err
);

  localparam int PW = (Np > 1) ? $clog2(Np) : 1;
  localparam int CW = (BLEN > 1) ? $clog2(BLEN) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(BLEN - 1);

  typedef enum logic [1:0] {Idle, Addr, Data, Gap} state_e;

  state_e                state_q;
  logic [PW-1:0]         rr_q;
  logic [PW-1:0]         gnt_q;
  logic [CW-1:0]         beat_q;
  logic [Np-1:0]         rack_q;
  logic [Np-1:0][63:0]   rdata_q;
  logic [31:0]           araddr_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  err_q;

  logic                  reqAny;
  logic [PW-1:0]         gnt_d;
  logic [PW-1:0]         scanIdx;
  logic [31:0]           addr_d;
  logic [PW-1:0]         rrNext;
  logic                  lastBeat;
  logic                  beatBad;

  // Scan downwards so the surviving hit is the first requester at or after rr_q.
  always_comb begin
    reqAny  = 1'b0;
    gnt_d   = '0;
    scanIdx = '0;
    for (int k = Np - 1; k >= 0; k--) begin
      scanIdx = PW'((int'(rr_q) + k) % Np);
      if (rreq[scanIdx]) begin
        reqAny = 1'b1;
        gnt_d  = scanIdx;
      end
    end
  end

  assign addr_d   = (rbase + {8'h00, radr[gnt_d]}) & 32'hFFFF_FC00;
  assign rrNext   = PW'((int'(gnt_q) + 1) % Np);
  assign lastBeat = (beat_q == LastBeat);
  assign beatBad  = (m_rresp != 2'b00) || (m_rlast != lastBeat);

  // Burst sequencer; the beat count, not rlast, decides when the burst ends.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q   <= Idle;
      rr_q      <= '0;
      gnt_q     <= '0;
      beat_q    <= '0;
      rack_q    <= '0;
      rdata_q   <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rack_q <= '0;
      case (state_q)
        Idle: begin
          if (reqAny) begin
            gnt_q     <= gnt_d;
            araddr_q  <= addr_d;
            arvalid_q <= 1'b1;
            state_q   <= Addr;
          end
        end
        Addr: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            rready_q  <= 1'b1;
            state_q   <= Data;
          end
        end
        Data: begin
          if (m_rvalid && rready_q) begin
            rack_q[gnt_q]  <= 1'b1;
            rdata_q[gnt_q] <= m_rdata;
            beat_q         <= beat_q + 1'b1;
            if (beatBad) begin
              err_q <= 1'b1;
            end
            if (lastBeat) begin
              rready_q <= 1'b0;
              rr_q     <= rrNext;
              state_q  <= Gap;
            end
          end
        end
        Gap: begin
          state_q <= Idle;
        end
        default: begin
          state_q <= Idle;
        end
      endcase
    end
  end

  assign rack      = rack_q;
  assign rdata     = rdata_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = 8'(BLEN - 1);
  assign m_arsize  = 3'b011;
  assign m_arburst = 2'b01;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign busy      = (state_q != Idle);
  assign err       = err_q;

endmodule

// File: tb/tb_rd_burst_server.sv
// Bench for rd_burst_server: an AXI slave plus transaction-level model checks
// every cycle, while the main sequence walks through directed scenarios.
module tb_rd_burst_server;

  localparam int Np   = 4;
  localparam int BLEN = 128;
  localparam int PW   = 2;

  typedef enum int {MIdle, MAddr, MData, MGap} mphase_e;

  logic                aclk;
  logic                arst;
  logic [Np-1:0]       rreq;
  logic [Np-1:0]       rack;
  logic [Np-1:0][23:0] radr;
  logic [Np-1:0][63:0] rdata;
  logic [31:0]         rbase;
  logic [31:0]         m_araddr;
  logic [7:0]          m_arlen;
  logic [2:0]          m_arsize;
  logic [1:0]          m_arburst;
  logic                m_arvalid;
  logic                m_arready;
  logic [63:0]         m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic                m_rvalid;
  logic                m_rready;
  logic                busy;
  logic                err;

  int checks = 0;
  int errors = 0;

  int  arDelay      = 0;
  int  rMode        = 0;
  int  rrespErrBeat = -1;
  int  rlastErrBeat = -1;
  bit  countData    = 1'b1;

  mphase_e       phase       = MIdle;
  bit            modelArmed  = 1'b0;
  int            gExp        = 0;
  int            rrExp       = 0;
  int            beatIdx     = 0;
  int            arWait      = 0;
  int            arHoldCount = 0;
  int            burstsDone  = 0;
  bit            errNext     = 1'b0;
  bit            errVis      = 1'b0;
  bit            seenBurst   = 1'b0;
  bit            rToggle     = 1'b1;
  logic [31:0]   expAddr     = '0;
  logic [31:0]   lastArAddr  = '0;
  logic [Np-1:0] expRack     = '0;
  logic [63:0]   lastData [Np];
  int            rackCount [Np];
  int            grantOrder [$];

  rd_burst_server #(.Np(Np), .BLEN(BLEN)) dut (
    .aclk      (aclk),
    .arst      (arst),
    .rreq      (rreq),
    .rack      (rack),
    .radr      (radr),
    .rdata     (rdata),
    .rbase     (rbase),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int pickGrant(input logic [Np-1:0] req, input int rr);
    for (int k = 0; k < Np; k++) begin
      if (req[PW'((rr + k) % Np)]) return (rr + k) % Np;
    end
    return -1;
  endfunction

  // AXI slave and reference model: drives at negedge, checks what the
  // previous negedge's decisions should have produced.
  initial begin : axiModel
    logic [63:0] beatData;
    logic [31:0] sum;
    bit          v;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    for (int i = 0; i < Np; i++) begin
      lastData[i]  = '0;
      rackCount[i] = 0;
    end
    forever begin
      @(negedge aclk);
      if (modelArmed) begin
        errVis = errNext;
        checkOutput("rack", 64'(rack), 64'(expRack));
        for (int i = 0; i < Np; i++) begin
          checkOutput($sformatf("rdata%0d", i), rdata[PW'(i)], lastData[i]);
        end
        checkOutput("err", 64'(err), 64'(errVis));
        for (int i = 0; i < Np; i++) begin
          if (rack[PW'(i)] === 1'b1) begin
            rackCount[i]++;
            if (!seenBurst) begin
              grantOrder.push_back(i);
              seenBurst = 1'b1;
            end
          end
        end
      end
      expRack = '0;
      if (arst) begin
        modelArmed = 1'b1;
        phase      = MIdle;
        rrExp      = 0;
        errNext    = 1'b0;
        for (int i = 0; i < Np; i++) lastData[i] = '0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        m_rresp    = '0;
      end else if (modelArmed) begin
        case (phase)
          MIdle: begin
            checkOutput("busyIdle", 64'(busy), 64'd0);
            checkOutput("arvalidIdle", 64'(m_arvalid), 64'd0);
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            m_rlast   = 1'b0;
            if (rreq != '0) begin
              gExp        = pickGrant(rreq, rrExp);
              sum         = rbase + {8'h00, radr[PW'(gExp)]};
              expAddr     = (sum / 32'd1024) * 32'd1024;
              arWait      = 0;
              arHoldCount = 0;
              seenBurst   = 1'b0;
              phase       = MAddr;
            end
          end
          MAddr: begin
            checkOutput("arvalid", 64'(m_arvalid), 64'd1);
            checkOutput("araddr", 64'(m_araddr), 64'(expAddr));
            checkOutput("arlen", 64'(m_arlen), 64'h7F);
            checkOutput("arsize", 64'(m_arsize), 64'd3);
            checkOutput("arburst", 64'(m_arburst), 64'd1);
            checkOutput("busyAddr", 64'(busy), 64'd1);
            arHoldCount++;
            m_rvalid = 1'b0;
            if (arWait < arDelay) begin
              m_arready = 1'b0;
              arWait++;
            end else begin
              m_arready  = 1'b1;
              lastArAddr = m_araddr;
              beatIdx    = 0;
              rToggle    = 1'b1;
              phase      = MData;
            end
          end
          MData: begin
            m_arready = 1'b0;
            checkOutput("arvalidData", 64'(m_arvalid), 64'd0);
            checkOutput("rready", 64'(m_rready), 64'd1);
            checkOutput("busyData", 64'(busy), 64'd1);
            case (rMode)
              0: v = 1'b1;
              1: begin
                v       = rToggle;
                rToggle = ~rToggle;
              end
              default: v = ($urandom_range(0, 1) == 1);
            endcase
            if (v) begin
              beatData = countData ? 64'(beatIdx) : {$urandom, $urandom};
              m_rvalid = 1'b1;
              m_rdata  = beatData;
              m_rresp  = (beatIdx == rrespErrBeat) ? 2'b10 : 2'b00;
              m_rlast  = (beatIdx == BLEN - 1) != (beatIdx == rlastErrBeat);
              if (beatIdx == rrespErrBeat || beatIdx == rlastErrBeat) errNext = 1'b1;
              lastData[gExp] = beatData;
              expRack = Np'(1) << gExp;
              beatIdx++;
              if (beatIdx == BLEN) begin
                rrExp = (gExp + 1) % Np;
                phase = MGap;
              end
            end else begin
              m_rvalid = 1'b0;
              m_rlast  = 1'b0;
              m_rresp  = 2'($urandom);
              m_rdata  = {$urandom, $urandom};
            end
          end
          MGap: begin
            checkOutput("busyGap", 64'(busy), 64'd1);
            checkOutput("rreadyGap", 64'(m_rready), 64'd0);
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            m_rresp  = '0;
            burstsDone++;
            phase = MIdle;
          end
          default: phase = MIdle;
        endcase
      end
    end
  end

  task automatic doReset();
    arst = 1'b1;
    rreq = '0;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    arst = 1'b0;
  endtask

  task automatic resetState(input string tag);
    checkOutput({tag, "Busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "Arvalid"}, 64'(m_arvalid), 64'd0);
    checkOutput({tag, "Araddr"}, 64'(m_araddr), 64'd0);
    checkOutput({tag, "Rready"}, 64'(m_rready), 64'd0);
    checkOutput({tag, "Rack"}, 64'(rack), 64'd0);
    checkOutput({tag, "Err"}, 64'(err), 64'd0);
    for (int i = 0; i < Np; i++) checkOutput({tag, "Rdata"}, rdata[PW'(i)], 64'd0);
  endtask

  task automatic applyStimulus(input logic [Np-1:0] reqMask, input int nBursts);
    int target;
    int budget;
    target = burstsDone + nBursts;
    budget = 1200 * nBursts;
    for (int i = 0; i < Np; i++) rackCount[i] = 0;
    rreq = reqMask;
    while (burstsDone < target && budget > 0) begin
      @(posedge aclk);
      #1;
      budget--;
    end
    rreq = '0;
    checkOutput("burstTimeout", 64'(burstsDone < target), 64'd0);
  endtask

  initial begin : mainSeq
    int budget;
    int expOrder [5];
    expOrder = '{0, 1, 2, 3, 0};
    arst  = 1'b1;
    rreq  = '0;
    radr  = '0;
    rbase = '0;
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    resetState("init");
    arst = 1'b0;

    $display("[TB] single channel, counting data");
    rbase   = 32'h1000_0000;
    radr[0] = 24'h000400;
    applyStimulus(4'b0001, 1);
    checkOutput("t1Araddr", 64'(lastArAddr), 64'h1000_0400);
    checkOutput("t1Beats", 64'(rackCount[0]), 64'd128);
    checkOutput("t1Err", 64'(err), 64'd0);

    $display("[TB] AR back-pressure");
    countData = 1'b0;
    arDelay   = 5;
    rbase     = $urandom;
    radr[0]   = 24'($urandom);
    applyStimulus(4'b0001, 1);
    checkOutput("t2ArHold", 64'(arHoldCount), 64'd6);
    arDelay = 0;

    $display("[TB] R gaps");
    rMode = 1;
    applyStimulus(4'b0001, 1);
    checkOutput("t3Beats", 64'(rackCount[0]), 64'd128);

    $display("[TB] four-way round robin");
    rMode = 2;
    doReset();
    rbase = $urandom;
    for (int i = 0; i < Np; i++) radr[i] = 24'($urandom);
    grantOrder.delete();
    applyStimulus(4'b1111, 5);
    checkOutput("t4OrderLen", 64'(grantOrder.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4Order", 64'((grantOrder.size() > k) ? grantOrder[k] : -1), 64'(expOrder[k]));
    end
    checkOutput("t4Beats0", 64'(rackCount[0]), 64'd256);
    checkOutput("t4Beats3", 64'(rackCount[3]), 64'd128);

    $display("[TB] rresp error then clean burst");
    rrespErrBeat = 5;
    applyStimulus(4'b0010, 1);
    checkOutput("t5ErrSet", 64'(err), 64'd1);
    rrespErrBeat = -1;
    applyStimulus(4'b0100, 1);
    checkOutput("t5ErrSticky", 64'(err), 64'd1);
    doReset();
    checkOutput("t5ErrCleared", 64'(err), 64'd0);

    $display("[TB] early rlast");
    rlastErrBeat = 100;
    applyStimulus(4'b0001, 1);
    checkOutput("t6Beats", 64'(rackCount[0]), 64'd128);
    checkOutput("t6Err", 64'(err), 64'd1);
    rlastErrBeat = -1;
    doReset();

    $display("[TB] reset mid-burst");
    rMode   = 0;
    rbase   = 32'h2000_0000;
    radr[0] = 24'h001555;
    rreq    = 4'b0001;
    budget  = 1000;
    while (!(phase == MData && beatIdx >= 60) && budget > 0) begin
      @(posedge aclk);
      #1;
      budget--;
    end
    checkOutput("t7ReachBeat60", 64'(budget == 0), 64'd0);
    arst = 1'b1;
    @(posedge aclk);
    #1;
    resetState("t7Rst");
    arst = 1'b0;
    applyStimulus(4'b0001, 1);
    checkOutput("t7Araddr", 64'(lastArAddr), 64'h2000_1400);
    checkOutput("t7Beats", 64'(rackCount[0]), 64'd128);

    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
